alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Initiator-side front end for `alu_top`. Accepts ALU commands on a valid/ready channel, issues a one-cycle `start` with operands held stable, waits for `done`, captures the 16-bit result and returns it on a valid/ready response channel. A watchdog aborts an operation that never completes. It sits between a command source (register file or test controller) and `alu_top`, one command in flight at a time.

## Interface
- `TIMEOUT_CYCLES`, 64: WAIT cycles without a `done` rising edge before abort; legal range 2..255.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  sequencer can accept a command; high only in IDLE.
- `cmd_op`  input  3  ALU opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR.
- `cmd_a`, `cmd_b`  input  8  operands, signed two's complement.
- `alu_start`  output  1  one-cycle start pulse to `alu_top`.
- `alu_op`  output  3  opcode to `alu_top`.
- `alu_in_a`, `alu_in_b`  output  8  operands to `alu_top`.
- `alu_done`  input  1  completion from `alu_top`; may remain high between operations.
- `alu_result`  input  16  result from `alu_top`.
- `rsp_valid`  output  1  response available.
- `rsp_ready`  input  1  consumer accepts response.
- `rsp_result`  output  16  captured result; 0 on timeout.
- `rsp_op`  output  3  opcode of the completed command.
- `rsp_timeout`  output  1  response produced by the watchdog, not by `alu_done`.
- `busy`  output  1  high in any state other than IDLE.
- `rsp_count`  output  8  responses handed off, wraps 255 -> 0.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, register op/a/b onto `alu_op`/`alu_in_a`/`alu_in_b` and go to ISSUE.
- ISSUE: `alu_start`=1 for exactly this cycle. Clear the watchdog counter and go to WAIT.
- WAIT:
  - Completion is a rising edge of `alu_done`: `alu_done`=1 this cycle and the registered `alu_done_d`=0.
  - `alu_done_d` updates every cycle in all states. A stale high `done` left over from the previous operation therefore never completes a new one.
  - On completion: capture `alu_result` into `rsp_result`, copy `alu_op` to `rsp_op`, set `rsp_timeout`=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES`-1: `rsp_result`=0, `rsp_timeout`=1, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP:
  - `rsp_valid`=1. `rsp_result`, `rsp_op` and `rsp_timeout` hold stable until handshake.
  - On `rsp_valid & rsp_ready`: increment `rsp_count` (mod 256) and go to IDLE.
  - A `done` edge arriving in RESP is ignored.
- `alu_op`/`alu_in_a`/`alu_in_b` hold from ISSUE until the next command is accepted.
- No arithmetic in this block; results pass through unmodified (16-bit signed as produced by `alu_top`).
- Reset (asynchronous, any state including mid-WAIT):
  - State goes to IDLE.
  - All outputs go to 0 immediately, except `cmd_ready`, which goes to 1.
  - `alu_done_d`, the counter and `rsp_count` clear.
  - The aborted operation produces no response.

## Timing
- Command handshake at posedge N:
  - `alu_start` is high in cycle N+1 only.
  - WAIT starts in cycle N+2.
- `done` rising edge sampled at posedge M: `rsp_valid` is high from cycle M+1.
- Minimum command-to-response latency is 3 cycles plus the ALU latency.
- Response handshake at posedge R: `cmd_ready` is high in cycle R+1, so the next command can be accepted at posedge R+1.
- Timeout with `done` never asserted: `rsp_valid` rises `TIMEOUT_CYCLES`+2 cycles after the command handshake.
- `cmd_ready` and `rsp_valid` are never high in the same cycle.

## Test plan
- ADD, `cmd_a`=25, `cmd_b`=17 against a real `alu_top` -> exactly one `alu_start` pulse; `rsp_result`=42, `rsp_op`=000, `rsp_timeout`=0, `rsp_count`=1.
- MUL sequence 10×5, 10×-5, -10×5, -10×-5 back-to-back with `rsp_ready` tied high -> results 50, -50, -50, 50 in order; `rsp_count`=4; `cmd_ready` low throughout each operation.
- Back-pressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` -> `rsp_result` stable, `cmd_ready`=0, a second `cmd_valid` is not accepted; after `rsp_ready`=1, `cmd_ready` rises the next cycle.
- Stale `done`: model ALU holds `alu_done`=1 from the previous operation and drops it 2 cycles after the new `start`, then raises it 3 cycles later with result 0x1234 -> response 0x1234, never the stale value.
- Timeout: `TIMEOUT_CYCLES`=8, model never raises `done` -> `rsp_valid` 10 cycles after the command handshake with `rsp_result`=0 and `rsp_timeout`=1; the next command completes normally.
- Reset asserted mid-WAIT -> `busy`=0, `alu_start`=0 and `rsp_valid`=0 immediately, `cmd_ready`=1; `rsp_count`=0 and no response after release.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command front end for alu_top: accepts one command, pulses start, waits for a done rising
// edge (or watchdog expiry) and returns the captured result on a valid/ready response channel.
module alu_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  // Command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  // ALU side
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_in_a,
  output logic [7:0]  alu_in_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  // Response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_timeout,
  // Status
  output logic        busy,
  output logic [7:0]  rsp_count
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end

  localparam logic [7:0] WdLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        done_prev_q;
  logic [7:0]  wd_q, wd_d;
  logic [15:0] res_q, res_d;
  logic [2:0]  rsp_op_q, rsp_op_d;
  logic        rsp_to_q, rsp_to_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_rise;

  // Only an edge counts, so a done level left over from the last operation is ignored.
  assign done_rise = alu_done & ~done_prev_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    wd_d     = wd_q;
    res_d    = res_q;
    rsp_op_d = rsp_op_q;
    rsp_to_d = rsp_to_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (done_rise) begin
          res_d    = alu_result;
          rsp_op_d = op_q;
          rsp_to_d = 1'b0;
          state_d  = StResp;
        end else if (wd_q == WdLast) begin
          res_d    = '0;
          rsp_op_d = op_q;
          rsp_to_d = 1'b1;
          state_d  = StResp;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      done_prev_q <= 1'b0;
      wd_q        <= '0;
      res_q       <= '0;
      rsp_op_q    <= '0;
      rsp_to_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      done_prev_q <= alu_done;
      wd_q        <= wd_d;
      res_q       <= res_d;
      rsp_op_q    <= rsp_op_d;
      rsp_to_q    <= rsp_to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign alu_start   = (state_q == StIssue);
  assign rsp_valid   = (state_q == StResp);
  assign busy        = (state_q != StIdle);
  assign alu_op      = op_q;
  assign alu_in_a    = a_q;
  assign alu_in_b    = b_q;
  assign rsp_result  = res_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_timeout = rsp_to_q;
  assign rsp_count   = cnt_q;

  a_ready_valid_exclusive: assert property (
    @(posedge clk) disable iff (!reset) !(cmd_ready && rsp_valid));

  a_start_single_cycle: assert property (
    @(posedge clk) disable iff (!reset) alu_start |=> !alu_start);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU that holds done high between
// operations; the monitor pops expected responses on every response handshake.
module tb_alu_cmd_sequencer;

  localparam int unsigned Tmo = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_in_a;
  logic [7:0]  alu_in_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        busy;
  logic [7:0]  rsp_count;

  alu_cmd_sequencer #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_in_a    (alu_in_a),
    .alu_in_b    (alu_in_b),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_op      (rsp_op),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .rsp_count   (rsp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  op;
    logic        to;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_cmds = 0;
  int n_starts = 0;
  int overlap = 0;
  int ready_viol = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Behavioural ALU: drops done 2 cycles after start, raises it with the result 3 later.
  bit          never_done = 1'b0;
  bit          force_res = 1'b0;
  logic [15:0] force_val = '0;
  logic [2:0]  m_op;
  logic [7:0]  m_a, m_b;
  int          m_cnt;
  bit          m_active;

  function automatic logic [15:0] calc(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    case (op)
      3'd0:    return sa + sb;
      3'd1:    return sa - sb;
      3'd2:    return sa * sb;
      3'd3:    return (sb == 0) ? 16'h0 : sa / sb;
      3'd4:    return {8'h00, a & b};
      3'd5:    return {8'h00, a | b};
      3'd6:    return {8'h00, a ^ b};
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_done   <= 1'b0;
      alu_result <= '0;
      m_active   <= 1'b0;
      m_cnt      <= 0;
    end else if (alu_start) begin
      m_active <= 1'b1;
      m_cnt    <= 0;
      m_op     <= alu_op;
      m_a      <= alu_in_a;
      m_b      <= alu_in_b;
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == 2) alu_done <= 1'b0;
      if (m_cnt + 1 == 5) begin
        m_active <= 1'b0;
        if (!never_done) begin
          alu_done   <= 1'b1;
          alu_result <= force_res ? force_val : calc(m_op, m_a, m_b);
        end
      end
    end
  end

  // Monitor: latency is counted in posedges from the command handshake to rsp_valid rising.
  int   lat_cnt = 0;
  int   lat_seen = -1;
  bit   inflight = 1'b0;
  logic [7:0] exp_count = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        inflight  = 1'b0;
        exp_count = '0;
        lat_cnt   = 0;
        lat_seen  = -1;
      end else begin
        if (alu_start) n_starts++;
        if (cmd_ready && rsp_valid) overlap++;
        if (inflight && cmd_ready) ready_viol++;
        if (inflight) lat_cnt++;
        if (rsp_valid && lat_seen < 0) lat_seen = lat_cnt;
        if (rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rsp: got result 0x%0h with no command pending",
                     rsp_result);
          end else begin
            e = sb_q.pop_front();
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_op", 32'(rsp_op), 32'(e.op));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            check("rsp_count_at_hs", 32'(rsp_count), 32'(exp_count));
            check("rsp_latency", 32'(lat_seen), 32'(e.lat));
          end
          inflight  = 1'b0;
          exp_count = exp_count + 8'd1;
        end
        if (cmd_valid && cmd_ready) begin
          inflight = 1'b1;
          lat_cnt  = 0;
          lat_seen = -1;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] res, input logic to, input int lat, input bit push);
    int guard = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    do begin
      @(negedge clk);
      guard++;
    end while (!cmd_ready && guard < 200);
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    if (cmd_ready) begin
      if (push) sb_q.push_back('{res: res, op: op, to: to, lat: lat});
      n_cmds++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(sb_q.size() == 0 && cmd_ready) && guard < 300);
    check("drain_idle", 32'(sb_q.size() == 0 && cmd_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish before 100000ns");
    $fatal(1, "bench timed out");
  end

  initial begin
    int guard;
    #2;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_alu_start", 32'(alu_start), 32'd0);
    check("reset_rsp_count", 32'(rsp_count), 32'd0);
    check("reset_rsp_result", 32'(rsp_result), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Single ADD
    send(3'd0, 8'd25, 8'd17, 16'd42, 1'b0, 8, 1'b1);
    wait_idle();
    check("add_rsp_count", 32'(rsp_count), 32'd1);
    check("add_start_pulses", 32'(n_starts), 32'd1);

    // Signed MUL sequence, back-to-back
    send(3'd2, 8'd10, 8'd5, 16'h0032, 1'b0, 8, 1'b1);
    send(3'd2, 8'd10, 8'hFB, 16'hFFCE, 1'b0, 8, 1'b1);
    send(3'd2, 8'hF6, 8'd5, 16'hFFCE, 1'b0, 8, 1'b1);
    send(3'd2, 8'hF6, 8'hFB, 16'h0032, 1'b0, 8, 1'b1);
    wait_idle();
    check("mul_rsp_count", 32'(rsp_count), 32'd5);

    // Back-pressure with a second command pending
    rsp_ready = 1'b0;
    send(3'd6, 8'h0F, 8'h33, 16'h003C, 1'b0, 8, 1'b1);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rsp_valid && guard < 50);
    check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = 3'd1;
      cmd_a     = 8'd5;
      cmd_b     = 8'd9;
      @(negedge clk);
      check("bp_result_stable", 32'(rsp_result), 32'h003C);
      check("bp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after_rsp", 32'(cmd_ready), 32'd1);
    if (cmd_ready) begin
      sb_q.push_back('{res: 16'hFFFC, op: 3'd1, to: 1'b0, lat: 8});
      n_cmds++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle();
    check("bp_rsp_count", 32'(rsp_count), 32'd7);

    // Stale done: previous done is still high when the new start arrives
    check("stale_done_high", 32'(alu_done), 32'd1);
    force_res = 1'b1;
    force_val = 16'h1234;
    send(3'd4, 8'hFF, 8'h0F, 16'h1234, 1'b0, 8, 1'b1);
    wait_idle();
    force_res = 1'b0;

    // Watchdog, then a normal command
    never_done = 1'b1;
    send(3'd5, 8'h01, 8'h02, 16'h0000, 1'b1, Tmo + 2, 1'b1);
    wait_idle();
    never_done = 1'b0;
    send(3'd4, 8'hF0, 8'h3C, 16'h0030, 1'b0, 8, 1'b1);
    wait_idle();
    check("tmo_rsp_count", 32'(rsp_count), 32'd10);

    // Reset in the middle of WAIT
    send(3'd2, 8'd3, 8'd3, 16'd9, 1'b0, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_count", 32'(rsp_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_rsp_count", 32'(rsp_count), 32'd0);
    send(3'd0, 8'hFD, 8'd1, 16'hFFFE, 1'b0, 8, 1'b1);
    wait_idle();
    check("post_rst_count", 32'(rsp_count), 32'd1);

    check("start_pulses_total", 32'(n_starts), 32'(n_cmds));
    check("ready_valid_overlap", 32'(overlap), 32'd0);
    check("cmd_ready_in_flight", 32'(ready_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
